// File: rtl/systolic_feeder.sv
// Operand sequencer for an NxN output-stationary systolic array: stores A and B,
// clears the accumulators, then streams skewed rows of A west and columns of B north.
module systolic_feeder #(
    parameter int BW = 8,
    parameter int N  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(N)-1:0]   wr_row,
    input  logic [$clog2(N)-1:0]   wr_col,
    input  logic [BW-1:0]          wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   acc_clr,
    output logic [N*BW-1:0]        x_edge,
    output logic [N*BW-1:0]        y_edge
);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(3 * N);
    localparam logic [IW:0]   N_LIM     = (IW + 1)'(N);
    localparam logic [TW-1:0] FEED_LAST = TW'(3 * N - 3);
    localparam logic [TW-1:0] DRN_LAST  = TW'(N - 1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic [BW-1:0]   a_q [N][N];
    logic [BW-1:0]   b_q [N][N];
    logic            busy_q, done_q, clr_q;
    logic [N*BW-1:0] x_q, x_d, y_q, y_d;
    logic            wr_ok_s;
    logic            feed_s;

    // Sequencer: t counts FEED steps, then is reused to count DRAIN cycles
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    t_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                if (t_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                end else begin
                    t_d = t_q + T_ONE;
                end
            end
            S_DRAIN: begin
                if (t_q == DRN_LAST) begin
                    state_d = S_DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + T_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    assign feed_s = (state_d == S_FEED);

    // Edge operands for the coming cycle: row/column i carries element k when t == i + k
    always_comb begin
        x_d = '0;
        y_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                x_d[i*BW +: BW] = x_d[i*BW +: BW] |
                    ((feed_s && (t_d == TW'(i + k))) ? a_q[i][k] : '0);
                y_d[i*BW +: BW] = y_d[i*BW +: BW] |
                    ((feed_s && (t_d == TW'(i + k))) ? b_q[k][i] : '0);
            end
        end
    end

    assign wr_ok_s = wr_en && ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                     ({1'b0, wr_row} < N_LIM) && ({1'b0, wr_col} < N_LIM);

    // FSM state, step counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            busy_q  <= (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
            clr_q   <= (state_d == S_CLEAR);
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Operand storage; only writable while the sequencer is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_q[i][k] <= '0;
                    b_q[i][k] <= '0;
                end
            end
        end else if (wr_ok_s) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if ((wr_row == IW'(i)) && (wr_col == IW'(k))) begin
                        if (wr_sel) begin
                            b_q[i][k] <= wr_data;
                        end else begin
                            a_q[i][k] <= wr_data;
                        end
                    end
                end
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign acc_clr = clr_q;
    assign x_edge  = x_q;
    assign y_edge  = y_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: per-cycle expected outputs from the skew
// rules, plus a bench-side PU array whose results are checked against A*B.
module tb_systolic_feeder;
    localparam int BW = 8;
    localparam int N  = 3;
    localparam int IW = $clog2(N);
    localparam int XW = N * BW;

    typedef struct packed {
        logic          clr;
        logic          busy;
        logic          done;
        logic [XW-1:0] x;
        logic [XW-1:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst, wr_en, wr_sel, start;
    logic [IW-1:0] wr_row, wr_col;
    logic [BW-1:0] wr_data;
    logic busy, done, acc_clr;
    logic [XW-1:0] x_edge, y_edge;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    int ma [N][N];
    int mb [N][N];
    exp_t exp_q [$];
    logic [N*N*16-1:0] res_q [$];

    logic [15:0]   acc [N][N];
    logic [BW-1:0] xr  [N][N];
    logic [BW-1:0] yr  [N][N];
    logic [BW-1:0] xin [N][N];
    logic [BW-1:0] yin [N][N];

    always #5 clk = ~clk;

    systolic_feeder #(.BW(BW), .N(N)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .acc_clr(acc_clr),
        .x_edge(x_edge), .y_edge(y_edge)
    );

    // Reference PU array inputs: operands move east along rows, south along columns
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                xin[i][j] = (j == 0) ? x_edge[i*BW +: BW] : xr[i][(j == 0) ? 0 : j - 1];
                yin[i][j] = (i == 0) ? y_edge[j*BW +: BW] : yr[(i == 0) ? 0 : i - 1][j];
            end
        end
    end

    // Reference PU array: 16-bit multiply-accumulate, cleared by acc_clr
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (acc_clr === 1'b1) begin
                    acc[i][j] <= 16'd0;
                    xr[i][j]  <= '0;
                    yr[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + 16'(xin[i][j]) * 16'(yin[i][j]);
                    xr[i][j]  <= xin[i][j];
                    yr[i][j]  <= yin[i][j];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected outputs in cycle c counted from the edge that accepted start
    function automatic exp_t exp_at(input int c);
        exp_t e;
        int   t;
        e      = '0;
        e.clr  = (c == 1);
        e.busy = (c >= 1) && (c <= 4 * N - 1);
        e.done = (c == 4 * N);
        if (c >= 2 && c <= 3 * N - 1) begin
            t = c - 2;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) e.x[i*BW +: BW] = BW'(ma[i][t - i]);
                if (t - i >= 0 && t - i < N) e.y[i*BW +: BW] = BW'(mb[t - i][i]);
            end
        end
        return e;
    endfunction

    function automatic logic [N*N*16-1:0] exp_prod();
        logic [N*N*16-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += ma[i][k] * mb[k][j];
                r[(i*N + j)*16 +: 16] = 16'(s);
            end
        end
        return r;
    endfunction

    // Monitor: compares every cycle; idle outputs are expected when nothing is queued
    always @(negedge clk) begin
        exp_t e;
        logic [N*N*16-1:0] r;
        if (mon_en) begin
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk("acc_clr", acc_clr, e.clr);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            chk("x_edge", x_edge, e.x);
            chk("y_edge", y_edge, e.y);
            if (done === 1'b1) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done_result", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++)
                            chk($sformatf("pu_%0d_%0d", i, j), acc[i][j], r[(i*N + j)*16 +: 16]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input int r, input int c, input int d);
        wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = BW'(d);
        tick();
        wr_en = 1'b0;
        if (r < N && c < N) begin
            if (sel) mb[r][c] = d;
            else     ma[r][c] = d;
        end
    endtask

    task automatic load_fixed();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wr(1'b0, i, j, 3 * i + j + 1);
                wr(1'b1, i, j, 9 - (3 * i + j));
            end
    endtask

    task automatic load_const(input int v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wr(1'b0, i, j, v);
                wr(1'b1, i, j, v);
            end
    endtask

    task automatic load_rand();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wr(1'b0, i, j, $urandom_range(0, 255));
                wr(1'b1, i, j, $urandom_range(0, 255));
            end
    endtask

    // One sequence; abuse adds ignored starts and writes, rst_at>0 resets in that cycle
    task automatic run(input bit abuse, input bit wr_with_start, input int rst_at);
        int r, c, d;
        bit s;
        if (wr_with_start) begin
            s = 1'($urandom_range(0, 1));
            r = $urandom_range(0, N - 1); c = $urandom_range(0, N - 1); d = $urandom_range(0, 255);
            wr_en = 1'b1; wr_sel = s; wr_row = IW'(r); wr_col = IW'(c); wr_data = BW'(d);
            if (s) mb[r][c] = d;
            else   ma[r][c] = d;
        end
        exp_q.push_back('0);
        for (int k = 1; k <= 4 * N; k++) exp_q.push_back(exp_at(k));
        res_q.push_back(exp_prod());
        start = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        for (int k = 1; k <= 4 * N; k++) begin
            start = abuse && (k == 3 || k == 4 * N);
            wr_en = abuse && (k >= 2) && (k <= 3 * N - 1);
            wr_sel = 1'($urandom_range(0, 1));
            wr_row = IW'($urandom_range(0, 3)); wr_col = IW'($urandom_range(0, 3));
            wr_data = BW'($urandom_range(0, 255));
            rst = (k == rst_at);
            tick();
            if (k == rst_at) begin
                rst = 1'b0; start = 1'b0; wr_en = 1'b0;
                exp_q.delete(); res_q.delete();
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        ma[i][j] = 0; mb[i][j] = 0;
                    end
                break;
            end
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        run(1'b0, 1'b0, 0);             // empty storage
        load_fixed();
        run(1'b0, 1'b0, 0);
        run(1'b0, 1'b0, 0);             // no reload: acc_clr must restart accumulation
        load_const(255);
        run(1'b0, 1'b0, 0);
        load_fixed();
        wr(1'b0, 3, 0, 8'h55);          // out-of-range row
        wr(1'b1, 0, 3, 8'h55);          // out-of-range column
        run(1'b1, 1'b0, 0);
        run(1'b0, 1'b0, 0);
        run(1'b0, 1'b0, 5);             // reset during FEED
        repeat (2) tick();
        load_fixed();
        run(1'b0, 1'b0, 0);
        for (int n = 0; n < 5; n++) begin
            load_rand();
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        repeat (3) tick();
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("res_q_drained", 64'(res_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
